// File: rtl/hc595_pkg.sv
// Shared types and sizing helpers for the 74HC595 cascade driver.
package hc595_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SHIFT_LO = 3'd1,
    SHIFT_HI = 3'd2,
    MR_LO    = 3'd3,
    LATCH_HI = 3'd4,
    LATCH_LO = 3'd5
  } state_t;

  localparam int BITS_PER_CHIP = 8;

  function automatic int word_w(input int n_chips);
    return BITS_PER_CHIP * n_chips;
  endfunction

  function automatic int bit_cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/hc595_chain_driver_if.sv
// Request-side handshake bundle of the 595 chain driver.
interface hc595_chain_driver_if #(
  parameter int N_CHIPS = 2
);
  localparam int W = hc595_pkg::word_w(N_CHIPS);

  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         lsb_first;
  logic         clear_req;

  modport master (
    output in_data,
    output in_valid,
    output lsb_first,
    output clear_req,
    input  in_ready
  );

  modport slave (
    input  in_data,
    input  in_valid,
    input  lsb_first,
    input  clear_req,
    output in_ready
  );

endinterface

// File: rtl/hc595_tick_gen.sv
// Free-running CLK_DIV divider; tick marks the last clock of each half-period.
module hc595_tick_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= (cnt_reg == CNT_MAX) ? '0 : cnt_reg + 1'b1;
    end
  end

  assign tick = en && (cnt_reg == CNT_MAX);

endmodule

// File: rtl/hc595_chain_driver.sv
// Serialises a word into a 74HC595 cascade, then latches it; also supports chain clear and blanking.
module hc595_chain_driver
  import hc595_pkg::*;
#(
  parameter int N_CHIPS = 2,
  parameter int CLK_DIV = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  hc595_chain_driver_if.slave   bus,
  input  logic                  blank,
  output logic                  ds,
  output logic                  shcp,
  output logic                  stcp,
  output logic                  mr_n,
  output logic                  oe_n,
  output logic                  busy,
  output logic                  done
);

  localparam int W   = word_w(N_CHIPS);
  localparam int BCW = bit_cnt_w(W);

  state_t           state_reg, state_next;
  logic [W-1:0]     sreg_reg, sreg_next;
  logic [BCW-1:0]   bit_cnt_reg, bit_cnt_next;
  logic             ds_reg, ds_next;
  logic             shcp_reg, shcp_next;
  logic             stcp_reg, stcp_next;
  logic             mr_n_reg, mr_n_next;
  logic             oe_n_reg, oe_n_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             in_ready_reg, in_ready_next;
  logic             latched_once_reg, latched_once_next;

  logic             tick;
  logic             div_clr;
  logic [W-1:0]     data_rev;
  logic [W-1:0]     load_word;

  hc595_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .en   (state_reg != IDLE),
    .clr  (div_clr),
    .tick (tick)
  );

  generate
    for (genvar gi = 0; gi < W; gi++) begin : g_rev
      assign data_rev[gi] = bus.in_data[W-1-gi];
    end
  endgenerate

  // The shift register always emits its MSB, so LSB-first is just a reversed load.
  assign load_word = bus.lsb_first ? data_rev : bus.in_data;

  always_comb begin
    state_next        = state_reg;
    sreg_next         = sreg_reg;
    bit_cnt_next      = bit_cnt_reg;
    ds_next           = ds_reg;
    latched_once_next = latched_once_reg;
    done_next         = 1'b0;
    div_clr           = 1'b0;

    case (state_reg)
      IDLE: begin
        if (in_ready_reg) begin
          if (bus.clear_req) begin
            div_clr    = 1'b1;
            state_next = MR_LO;
          end else if (bus.in_valid) begin
            div_clr      = 1'b1;
            sreg_next    = load_word;
            bit_cnt_next = BCW'(W - 1);
            ds_next      = load_word[W-1];
            state_next   = SHIFT_LO;
          end
        end
      end
      SHIFT_LO: begin
        if (tick) state_next = SHIFT_HI;
      end
      SHIFT_HI: begin
        if (tick) begin
          if (bit_cnt_reg == '0) begin
            state_next = LATCH_HI;
          end else begin
            sreg_next    = {sreg_reg[W-2:0], 1'b0};
            bit_cnt_next = bit_cnt_reg - 1'b1;
            ds_next      = sreg_reg[W-2];
            state_next   = SHIFT_LO;
          end
        end
      end
      MR_LO: begin
        if (tick) state_next = LATCH_HI;
      end
      LATCH_HI: begin
        if (tick) state_next = LATCH_LO;
      end
      LATCH_LO: begin
        if (tick) begin
          state_next        = IDLE;
          done_next         = 1'b1;
          latched_once_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // Pin levels follow the state being entered, so every pin is a flop output.
    shcp_next     = (state_next == SHIFT_HI);
    stcp_next     = (state_next == LATCH_HI);
    mr_n_next     = (state_next != MR_LO);
    busy_next     = (state_next != IDLE);
    in_ready_next = (state_next == IDLE);
    oe_n_next     = blank | ~latched_once_next;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg        <= IDLE;
      sreg_reg         <= '0;
      bit_cnt_reg      <= '0;
      ds_reg           <= 1'b0;
      shcp_reg         <= 1'b0;
      stcp_reg         <= 1'b0;
      mr_n_reg         <= 1'b0;
      oe_n_reg         <= 1'b1;
      busy_reg         <= 1'b0;
      done_reg         <= 1'b0;
      in_ready_reg     <= 1'b0;
      latched_once_reg <= 1'b0;
    end else begin
      state_reg        <= state_next;
      sreg_reg         <= sreg_next;
      bit_cnt_reg      <= bit_cnt_next;
      ds_reg           <= ds_next;
      shcp_reg         <= shcp_next;
      stcp_reg         <= stcp_next;
      mr_n_reg         <= mr_n_next;
      oe_n_reg         <= oe_n_next;
      busy_reg         <= busy_next;
      done_reg         <= done_next;
      in_ready_reg     <= in_ready_next;
      latched_once_reg <= latched_once_next;
    end
  end

  assign bus.in_ready = in_ready_reg;
  assign ds           = ds_reg;
  assign shcp         = shcp_reg;
  assign stcp         = stcp_reg;
  assign mr_n         = mr_n_reg;
  assign oe_n         = oe_n_reg;
  assign busy         = busy_reg;
  assign done         = done_reg;

endmodule
